pcileech_vfifo_packer: RTL and testbench

Packs the 32-bit word stream produced by the FIFO controller toward the host into 256-bit blocks for the DDR3-backed virtual FIFO input port. The vFIFO input requires that valid is never asserted on two consecutive clocks, and that valid is asserted only while vFIFO ready is high. This block enforces both rules, pads partial blocks on flush or idle timeout, and back-pressures the word source.

---
 rtl/pcileech_vfifo_packer_pkg.sv | 27 ++
 rtl/pcileech_idle_timer.sv | 36 +++
 rtl/pcileech_vfifo_packer.sv | 120 ++++++++++++
 tb/tb_pcileech_vfifo_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_vfifo_packer_pkg.sv
// rtl/pcileech_vfifo_packer_pkg.sv - shared widths, constants and types for the vFIFO packer
package pcileech_vfifo_packer_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int ACC_CNT_W       = 4;

  localparam logic [WORD_W-1:0] DEFAULT_FILLER = 32'h6666_5555;

  typedef logic [ACC_CNT_W-1:0] acc_cnt_t;

  localparam acc_cnt_t ACC_EMPTY = acc_cnt_t'(0);
  localparam acc_cnt_t ACC_FULL  = acc_cnt_t'(WORDS_PER_BLOCK);

  // A block travelling from the accumulator to the output buffer keeps its pad flag.
  typedef struct packed {
    logic               padded;
    logic [BLOCK_W-1:0] data;
  } block_t;

  // True when the accumulator holds a partial block (neither empty nor full).
  function automatic logic is_partial(input acc_cnt_t cnt);
    return (cnt != ACC_EMPTY) && (cnt != ACC_FULL);
  endfunction

endpackage

// File: rtl/pcileech_idle_timer.sv
// rtl/pcileech_idle_timer.sv - idle clock counter that flags a timeout after TIMEOUT clocks
module pcileech_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Count idle clocks; saturate so a long idle period can never wrap into a second hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
    end else if (enable && (idle_cnt != '1)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // A zero timeout disables the hit entirely.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign hit = 1'b0;
    end else begin : g_enabled
      assign hit = enable && (idle_cnt == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/pcileech_vfifo_packer.sv
// rtl/pcileech_vfifo_packer.sv - packs 32-bit words into 256-bit blocks for the vFIFO input
module pcileech_vfifo_packer
  import pcileech_vfifo_packer_pkg::*;
#(
  parameter int                PARAM_TIMEOUT = 64,
  parameter logic [WORD_W-1:0] PARAM_FILLER  = DEFAULT_FILLER
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic               din_flush,
  output logic [BLOCK_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [31:0]        stat_blocks,
  output logic [15:0]        stat_pads
);

  logic [BLOCK_W-1:0] acc;
  acc_cnt_t           acc_cnt;
  acc_cnt_t           post_cnt;
  logic               acc_padded;
  block_t             obuf;
  logic               obuf_full;

  logic accept;
  logic pad;
  logic transfer;
  logic emit;
  logic timer_clear;
  logic timer_hit;

  // Ready depends only on registered state so there is no path from din_valid.
  assign din_ready = rst_n && (acc_cnt != ACC_FULL);
  assign accept    = din_valid && din_ready;

  // Count after this cycle's accept; a word arriving with a flush is packed before padding.
  assign post_cnt  = acc_cnt + acc_cnt_t'(accept);
  assign pad       = (din_flush || timer_hit) && is_partial(post_cnt);

  // Move a full block to the output buffer only when the buffer and output strobe are idle.
  assign transfer  = (acc_cnt == ACC_FULL) && !obuf_full && !dout_valid;

  // The vFIFO needs a gap clock between strobes and ready high when the strobe is issued.
  assign emit      = obuf_full && dout_ready && !dout_valid;

  // The timer only runs while a partial block sits waiting for more words.
  assign timer_clear = accept || !is_partial(acc_cnt);

  pcileech_idle_timer #(
    .TIMEOUT (PARAM_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (1'b1),
    .hit    (timer_hit)
  );

  // Accumulator: store accepted words, fill unused slots on pad, empty on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_cnt    <= ACC_EMPTY;
      acc_padded <= 1'b0;
    end else begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        if (accept && (acc_cnt == acc_cnt_t'(i))) begin
          acc[i*WORD_W +: WORD_W] <= din;
        end else if (pad && (acc_cnt_t'(i) >= post_cnt)) begin
          acc[i*WORD_W +: WORD_W] <= PARAM_FILLER;
        end
      end
      if (transfer) begin
        acc_cnt    <= ACC_EMPTY;
        acc_padded <= 1'b0;
      end else if (pad) begin
        acc_cnt    <= ACC_FULL;
        acc_padded <= 1'b1;
      end else if (accept) begin
        acc_cnt    <= post_cnt;
      end
    end
  end

  // Output buffer: one block waiting for the vFIFO, freed when it is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf      <= '0;
      obuf_full <= 1'b0;
    end else if (transfer) begin
      obuf      <= '{padded: acc_padded, data: acc};
      obuf_full <= 1'b1;
    end else if (emit) begin
      obuf_full <= 1'b0;
    end
  end

  // Emit: single-cycle strobe, dout held until the next block, statistics counted here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      stat_blocks <= '0;
      stat_pads   <= '0;
    end else begin
      dout_valid <= emit;
      if (emit) begin
        dout        <= obuf.data;
        stat_blocks <= stat_blocks + 32'd1;
        if (obuf.padded) begin
          stat_pads <= stat_pads + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcileech_vfifo_packer.sv
// tb/tb_pcileech_vfifo_packer.sv - directed, table-driven bench for the vFIFO packer
module tb_pcileech_vfifo_packer;

  localparam logic [31:0] FIL = 32'h66665555;

  logic         clk;
  logic         rst_n;
  logic [31:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic         din_flush;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [31:0]  stat_blocks;
  logic [15:0]  stat_pads;

  pcileech_vfifo_packer #(
    .PARAM_TIMEOUT (64),
    .PARAM_FILLER  (32'h66665555)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .din_flush   (din_flush),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .stat_blocks (stat_blocks),
    .stat_pads   (stat_pads)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Block monitor, sampling on the falling edge.
  logic [255:0] blocks[$];
  int           block_cyc[$];
  logic         prev_valid   = 1'b0;
  logic         back_to_back = 1'b0;

  always @(negedge clk) begin
    if (dout_valid) begin
      blocks.push_back(dout);
      block_cyc.push_back(cyc);
    end
    if (dout_valid && prev_valid) back_to_back = 1'b1;
    prev_valid = dout_valid;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_blocks = 0;
  int exp_pads   = 0;
  int rd = 0;

  // mode: 0 = no flush, 1 = flush with the last word, 2 = separate flush pulse after it
  typedef struct {
    int           n;
    logic [31:0]  base;
    int           mode;
    logic [255:0] exp_dout;
    logic         exp_pad;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic fl);
    int g = 0;
    din = w; din_valid = 1'b1; din_flush = fl;
    while (!din_ready && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (!din_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_word_timeout: din_ready stuck low for word %h", w);
    end else begin
      @(posedge clk); #1;
    end
    din_valid = 1'b0; din_flush = 1'b0;
  endtask

  task automatic pulse_flush();
    din_flush = 1'b1;
    @(posedge clk); #1;
    din_flush = 1'b0;
  endtask

  task automatic wait_blocks(input int n, input string name);
    int g = 0;
    while (blocks.size() < n && g < 2000) begin
      @(posedge clk); #1; g++;
    end
    n_checks++;
    if (blocks.size() < n) begin
      n_fail++;
      $display("FAIL %s: blocks seen %0d required %0d", name, blocks.size(), n);
    end
  endtask

  task automatic check_stats(input string name);
    check({name, "_stat_blocks"}, 256'(stat_blocks), 256'(exp_blocks));
    check({name, "_stat_pads"}, 256'(stat_pads), 256'(exp_pads));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic next_block(input string name, input logic [255:0] exp);
    wait_blocks(rd + 1, {name, "_wait"});
    if (blocks.size() > rd) begin
      check(name, blocks[rd], exp);
      rd++;
    end
  endtask

  int t0;
  int base_sz;

  initial begin
    vecs[0] = '{3, 32'h0000000A, 2, {FIL, FIL, FIL, FIL, FIL, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 1'b1};
    vecs[1] = '{7, 32'h00000100, 1, {FIL, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100}, 1'b1};
    vecs[2] = '{8, 32'h00000200, 0, {32'h207, 32'h206, 32'h205, 32'h204, 32'h203, 32'h202, 32'h201, 32'h200}, 1'b0};
    vecs[3] = '{1, 32'hDEAD0000, 2, {FIL, FIL, FIL, FIL, FIL, FIL, FIL, 32'hDEAD0000}, 1'b1};
    vecs[4] = '{8, 32'h00000300, 1, {32'h307, 32'h306, 32'h305, 32'h304, 32'h303, 32'h302, 32'h301, 32'h300}, 1'b0};

    rst_n = 1'b0; din = '0; din_valid = 1'b0; din_flush = 1'b0; dout_ready = 1'b1;
    idle(3);
    check("reset_dout_valid", 256'(dout_valid), 256'(0));
    check("reset_dout", dout, 256'(0));
    check("reset_din_ready", 256'(din_ready), 256'(0));
    check_stats("reset");
    rst_n = 1'b1;
    idle(2);
    check("din_ready_after_reset", 256'(din_ready), 256'(1));

    // Two full blocks streamed at one word per clock.
    for (int i = 1; i <= 16; i++) send_word(32'(i), 1'b0);
    next_block("stream_blk0", {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    next_block("stream_blk1", {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9});
    exp_blocks += 2;
    n_checks++;
    if (block_cyc.size() >= 2 && (block_cyc[1] - block_cyc[0]) < 2) begin
      n_fail++;
      $display("FAIL stream_gap: got %0d clocks required >= 2", block_cyc[1] - block_cyc[0]);
    end
    check_stats("stream");

    // Table of partial / full / flush-coincident blocks.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        send_word(vecs[v].base + 32'(i), (vecs[v].mode == 1) && (i == vecs[v].n - 1));
      if (vecs[v].mode == 2) pulse_flush();
      next_block($sformatf("vec%0d_dout", v), vecs[v].exp_dout);
      exp_blocks++;
      if (vecs[v].exp_pad) exp_pads++;
      check_stats($sformatf("vec%0d", v));
    end

    // Flush with nothing accumulated produces nothing.
    base_sz = blocks.size();
    pulse_flush();
    idle(10);
    check("flush_empty_noop", 256'(blocks.size()), 256'(base_sz));

    // Idle timeout pads a 5-word block; strobe 64 + 2 clocks after the last accept.
    for (int i = 0; i < 5; i++) send_word(32'h500 + 32'(i), 1'b0);
    t0 = cyc;
    next_block("timeout_dout", {FIL, FIL, FIL, 32'h504, 32'h503, 32'h502, 32'h501, 32'h500});
    exp_blocks++; exp_pads++;
    if (block_cyc.size() >= rd) check("timeout_latency", 256'(block_cyc[rd-1] - t0), 256'(66));
    check_stats("timeout");

    // Backpressure: vFIFO not ready, 16 words fill obuf and acc, then din_ready drops.
    dout_ready = 1'b0;
    base_sz = blocks.size();
    for (int i = 0; i < 16; i++) send_word(32'h600 + 32'(i), 1'b0);
    idle(3);
    check("bp_din_ready_low", 256'(din_ready), 256'(0));
    idle(80);
    check("bp_no_emit", 256'(blocks.size()), 256'(base_sz));
    check("bp_din_ready_still_low", 256'(din_ready), 256'(0));
    dout_ready = 1'b1;
    for (int i = 16; i < 24; i++) send_word(32'h600 + 32'(i), 1'b0);
    next_block("bp_blk0", {32'h607, 32'h606, 32'h605, 32'h604, 32'h603, 32'h602, 32'h601, 32'h600});
    next_block("bp_blk1", {32'h60F, 32'h60E, 32'h60D, 32'h60C, 32'h60B, 32'h60A, 32'h609, 32'h608});
    next_block("bp_blk2", {32'h617, 32'h616, 32'h615, 32'h614, 32'h613, 32'h612, 32'h611, 32'h610});
    exp_blocks += 3;
    check_stats("bp");
    check("no_back_to_back_valid", 256'(back_to_back), 256'(0));

    // Reset mid-block discards the partial words.
    for (int i = 0; i < 4; i++) send_word(32'h700 + 32'(i), 1'b0);
    rst_n = 1'b0;
    idle(2);
    check("midrst_dout_valid", 256'(dout_valid), 256'(0));
    check("midrst_dout", dout, 256'(0));
    check("midrst_din_ready", 256'(din_ready), 256'(0));
    exp_blocks = 0; exp_pads = 0;
    check_stats("midrst");
    base_sz = blocks.size();
    rst_n = 1'b1;
    idle(2);
    check("midrst_no_partial_emit", 256'(blocks.size()), 256'(base_sz));
    for (int i = 0; i < 8; i++) send_word(32'h800 + 32'(i), 1'b0);
    next_block("post_reset_blk", {32'h807, 32'h806, 32'h805, 32'h804, 32'h803, 32'h802, 32'h801, 32'h800});
    exp_blocks++;
    check_stats("post_reset");
    check("post_reset_no_extra", 256'(blocks.size()), 256'(rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
